ula_div_seq: RTL and testbench
==============================

ULA_DIV_SEQ -- requirements
Module: ula_div_seq

Interface
REQ-001 Parameter NUBITS, default 32, data word width in bits; legal range 4..64.
REQ-002 Parameter OPDIV, default 4, op code selecting quotient.
REQ-003 Parameter OPMOD, default 5, op code selecting remainder.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  6  operation code, sampled with start.
REQ-008 in1  input  NUBITS  signed dividend, sampled with start.
REQ-009 in2  input  NUBITS  signed divisor, sampled with start.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when out is valid.
REQ-012 out  output  NUBITS  signed result; drives the ULA div/mod operand lines.
REQ-013 is_zero  output  1  high when out equals zero.
REQ-014 dz  output  1  divide-by-zero flag for the last result.

Function
REQ-015 FSM states: IDLE, CALC, FIX, DONE; encoding is the package constant set.
REQ-016 IDLE -> CALC when start=1 and op is OPDIV or OPMOD; otherwise stay in IDLE; all inputs are ignored.
REQ-017 On acceptance: latch op; latch |in1|, |in2| and the signs of in1 and in2; clear the partial remainder; load a down-counter with NUBITS.
REQ-018 CALC: one restoring shift-subtract step per cycle over an NUBITS+1-bit partial remainder; exactly NUBITS cycles, then FIX.
REQ-019 FIX, one cycle: quotient negated when the operand signs differ; remainder takes the sign of in1. Result is truncation toward zero, matching Verilog / and %.
REQ-020 DONE, one cycle: done=1; then -> IDLE.
REQ-021 Latency: done asserted exactly NUBITS+2 cycles after the edge that samples start.
REQ-022 busy=1 in CALC, FIX and DONE; busy=0 in IDLE.
REQ-023 start while busy is ignored; no queueing.
REQ-024 out, is_zero and dz update only on the FIX->DONE edge, then hold until the next result or reset.
REQ-025 in2=0: quotient all ones, remainder = in1, dz=1, same latency; otherwise dz=0.
REQ-026 in1 = most-negative and in2 = -1: quotient = most-negative (wraps), remainder = 0, dz=0.
REQ-027 Magnitude of the most-negative value is handled as unsigned NUBITS without overflow.
REQ-028 is_zero = (out == 0), registered with out.

Reset
REQ-029 rst=1 at any edge forces IDLE: busy=0, done=0, out=0, is_zero=1, dz=0, counter=0.
REQ-030 rst during CALC, FIX or DONE aborts the operation; no done pulse for it.
REQ-031 rst has priority over start on the same edge.

Structure
REQ-032 The shared package holds the FSM state typedef and the op code constants OP_DIV=6'd4 and OP_MOD=6'd5; the ULA decoder uses the same constants.
REQ-033 One combinational sub-module, div_step: one shift-subtract iteration (partial remainder, dividend bit in -> new remainder, quotient bit).
REQ-034 No combinational path from inputs to outputs.

Verification (NUBITS=32)
REQ-035 op=4, in1=100, in2=7, start -> done at cycle 34 after start; out=14, dz=0.
REQ-036 op=5, in1=-100, in2=7 -> out=-2; op=4 with the same operands -> out=-14; op=5, in1=100, in2=-7 -> out=2.
REQ-037 op=4, in1=5, in2=0 -> out=0xFFFFFFFF, dz=1; op=5 with the same operands -> out=5, dz=1.
REQ-038 op=4, in1=0x80000000, in2=0xFFFFFFFF -> out=0x80000000; op=5 with the same operands -> out=0, is_zero=1.
REQ-039 Second start issued at cycle 10 of an operation -> ignored; exactly one done pulse; first result intact.
REQ-040 rst pulse at cycle 15 of an operation -> busy=0 next cycle, out=0, no done; a new start then completes normally.

Source files
------------

// File: rtl/ula_div_seq_pkg.sv
// Shared definitions for the sequential ULA divider.
//   state_t : FSM state encoding (IDLE, CALC, FIX, DONE)
//   OP_DIV  : op code selecting the quotient
//   OP_MOD  : op code selecting the remainder
// The ULA decoder imports the same op code constants.
package ula_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [5:0] OP_DIV = 6'd4;
  localparam logic [5:0] OP_MOD = 6'd5;

endpackage

// File: rtl/ula_div_seq_div_step.sv
// One restoring shift-subtract iteration of an unsigned divider.
//   rem      : current partial remainder (W+1 bits)
//   bit_in   : next dividend bit shifted in at the LSB
//   divisor  : unsigned divisor magnitude (W bits)
//   rem_next : partial remainder after this step
//   q_bit    : quotient bit produced by this step
// Purely combinational.
module ula_div_seq_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // One extra guard bit so the borrow of the trial subtraction is visible.
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[W+1];
    rem_next = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/ula_div_seq.sv
// Sequential signed divider / remainder unit for the ULA.
//   clk     : clock, all state changes on the rising edge
//   rst     : synchronous active-high reset
//   start   : request, sampled only while idle
//   op      : operation code (OPDIV -> quotient, OPMOD -> remainder)
//   in1     : signed dividend
//   in2     : signed divisor
//   busy    : high while an operation is in progress
//   done    : one-cycle pulse when out holds a fresh result
//   out     : signed result, truncation toward zero
//   is_zero : out == 0, registered with out
//   dz      : divide-by-zero flag for the last result
// Magnitudes are divided unsigned over NUBITS cycles, signs are applied in FIX.
module ula_div_seq
  import ula_div_seq_pkg::*;
#(
  parameter int unsigned NUBITS = 32,
  parameter logic [5:0]  OPDIV  = OP_DIV,
  parameter logic [5:0]  OPMOD  = OP_MOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        op,
  input  logic [NUBITS-1:0] in1,
  input  logic [NUBITS-1:0] in2,
  output logic              busy,
  output logic              done,
  output logic [NUBITS-1:0] out,
  output logic              is_zero,
  output logic              dz
);

  localparam int unsigned CW = $clog2(NUBITS + 1);

  state_t            state;
  state_t            state_next;

  logic [CW-1:0]     count;
  logic [NUBITS-1:0] quo;       // dividend magnitude shifting out, quotient shifting in
  logic [NUBITS-1:0] dvsr;
  logic [NUBITS:0]   rem;
  logic              op_mod;
  logic              sign1;
  logic              sign2;

  logic              accept;
  logic              last_step;
  logic [NUBITS:0]   rem_step;
  logic              q_bit;
  logic [NUBITS-1:0] result;
  logic              div_zero;

  always_comb begin
    accept    = start && ((op == OPDIV) || (op == OPMOD));
    last_step = (count == CW'(1));
  end

  ula_div_seq_div_step #(
    .W (NUBITS)
  ) u_div_step (
    .rem      (rem),
    .bit_in   (quo[NUBITS-1]),
    .divisor  (dvsr),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)    state_next = ST_CALC;
      ST_CALC: if (last_step) state_next = ST_FIX;
      ST_FIX:                 state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient, and the
  // remainder then equals |in1| which re-signs back to in1.
  always_comb begin
    div_zero = (dvsr == '0);
    if (op_mod) begin
      result = sign1 ? -rem[NUBITS-1:0] : rem[NUBITS-1:0];
    end else if (div_zero) begin
      result = '1;
    end else begin
      result = (sign1 ^ sign2) ? -quo : quo;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      quo     <= '0;
      dvsr    <= '0;
      rem     <= '0;
      op_mod  <= 1'b0;
      sign1   <= 1'b0;
      sign2   <= 1'b0;
      out     <= '0;
      is_zero <= 1'b1;
      dz      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_mod <= (op == OPMOD);
            sign1  <= in1[NUBITS-1];
            sign2  <= in2[NUBITS-1];
            // Negating the most-negative value yields itself, which is the
            // correct unsigned magnitude.
            quo    <= in1[NUBITS-1] ? -in1 : in1;
            dvsr   <= in2[NUBITS-1] ? -in2 : in2;
            rem    <= '0;
            count  <= CW'(NUBITS);
          end
        end
        ST_CALC: begin
          rem   <= rem_step;
          quo   <= {quo[NUBITS-2:0], q_bit};
          count <= count - CW'(1);
        end
        ST_FIX: begin
          out     <= result;
          is_zero <= (result == '0);
          dz      <= div_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_div_seq.sv
module tb_ula_div_seq;
  import ula_div_seq_pkg::*;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   op;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         is_zero;
  logic         dz;

  int checks = 0;
  int errors = 0;

  ula_div_seq #(
    .NUBITS (N),
    .OPDIV  (OP_DIV),
    .OPMOD  (OP_MOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .is_zero (is_zero),
    .dz      (dz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic truncated back to N bits.
  function automatic void model(input logic [5:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] r, output logic d);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      d = 1'b1;
      r = (o == OP_DIV) ? '1 : a;
    end else begin
      d = 1'b0;
      r = (o == OP_DIV) ? N'(sa / sb) : N'(sa % sb);
    end
  endfunction

  // Issues one operation and watches N+10 cycles. dup_at >= 0 raises a
  // second start at that cycle index of the operation.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [N-1:0] a,
                        input logic [N-1:0] b, input int dup_at);
    logic [N-1:0] eo;
    logic         ed;
    int           pulses;
    bit           seen;
    model(o, a, b, eo, ed);
    @(negedge clk);
    op = o; in1 = a; in2 = b; start = 1'b1;
    pulses = 0;
    seen   = 1'b0;
    // Observation j is taken at the negedge following the j-th edge after
    // the sampling edge; a register fed by done captures it one edge later.
    for (int j = 0; j < int'(N) + 10; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == dup_at) begin
        op = OP_DIV; in1 = $urandom; in2 = 32'd1; start = 1'b1;
      end
      if (j == 0) check_eq({tag, "/busy"}, 64'(busy), 64'd1);
      if (done) begin
        pulses++;
        if (!seen) begin
          seen = 1'b1;
          check_eq({tag, "/latency"}, 64'(j + 1), 64'(N + 2));
          check_eq({tag, "/out"}, 64'(out), 64'(eo));
          check_eq({tag, "/dz"}, 64'(dz), 64'(ed));
          check_eq({tag, "/is_zero"}, 64'(is_zero), 64'(eo == '0));
        end
      end
    end
    start = 1'b0;
    if (!seen) check_eq({tag, "/timeout"}, 64'd0, 64'd1);
    check_eq({tag, "/pulses"}, 64'(pulses), 64'd1);
    check_eq({tag, "/idle"}, 64'(busy), 64'd0);
    check_eq({tag, "/hold"}, 64'(out), 64'(eo));
  endtask

  initial begin
    logic [5:0]   ro;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] prev;
    int           pulses;

    rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst/busy", 64'(busy), 64'd0);
    check_eq("rst/done", 64'(done), 64'd0);
    check_eq("rst/out", 64'(out), 64'd0);
    check_eq("rst/is_zero", 64'(is_zero), 64'd1);
    check_eq("rst/dz", 64'(dz), 64'd0);
    rst = 1'b0;

    run_op("div_100_7", OP_DIV, 32'd100, 32'd7, -1);
    run_op("mod_m100_7", OP_MOD, -32'sd100, 32'd7, -1);
    run_op("div_m100_7", OP_DIV, -32'sd100, 32'd7, -1);
    run_op("mod_100_m7", OP_MOD, 32'd100, -32'sd7, -1);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, -1);
    run_op("mod_5_0", OP_MOD, 32'd5, 32'd0, -1);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("mod_min_m1", OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("div_m9_0", OP_DIV, -32'sd9, 32'd0, -1);
    run_op("mod_min_0", OP_MOD, 32'h8000_0000, 32'd0, -1);
    run_op("dup_start", OP_DIV, 32'd1000, 32'd9, 10);

    // Unsupported op code must not start anything.
    prev = out;
    @(negedge clk);
    op = 6'd3; in1 = 32'd50; in2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("badop/busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check_eq("badop/done", 64'(done), 64'd0);
    check_eq("badop/out", 64'(out), 64'(prev));

    // Reset sampled at cycle 15 of an operation aborts it.
    @(negedge clk);
    op = OP_DIV; in1 = 32'd1000; in2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort/busy", 64'(busy), 64'd0);
    check_eq("abort/done", 64'(done), 64'd0);
    check_eq("abort/out", 64'(out), 64'd0);
    check_eq("abort/is_zero", 64'(is_zero), 64'd1);
    check_eq("abort/dz", 64'(dz), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check_eq("abort/pulses", 64'(pulses), 64'd0);
    run_op("after_abort", OP_DIV, 32'd1000, 32'd3, -1);

    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_MOD;
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF;
        4:       rb = $urandom >> $urandom_range(8, 31);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ro, ra, rb, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
